// File: rtl/pipe_fwd_pkg.sv
// Shared forwarding-select codes and stall state encoding for the ID/EX operand stages.
package pipe_fwd_pkg;

    localparam logic [2:0] FWD_RF         = 3'd0;
    localparam logic [2:0] FWD_IDEX_LINK  = 3'd1;
    localparam logic [2:0] FWD_EXMEM_ALU  = 3'd2;
    localparam logic [2:0] FWD_EXMEM_LINK = 3'd3;
    localparam logic [2:0] FWD_MEMWB      = 3'd4;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL1 = 2'd1;
    localparam logic [1:0] ST_STALL2 = 2'd2;

endpackage

// File: rtl/rt_fwd_mux.sv
// Combinational 5-way rt operand select; unused codes fall back to the register file.
module rt_fwd_mux
    import pipe_fwd_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    sel,
    input  logic [DW-1:0] rfData,
    input  logic [DW-1:0] idExLink,
    input  logic [DW-1:0] exMemAlu,
    input  logic [DW-1:0] exMemLink,
    input  logic [DW-1:0] memWbData,
    output logic [DW-1:0] fwdData
);

    // Pick the forwarded source; illegal codes behave like "no forwarding".
    always_comb begin
        fwdData = rfData;
        case (sel)
            FWD_RF:         fwdData = rfData;
            FWD_IDEX_LINK:  fwdData = idExLink;
            FWD_EXMEM_ALU:  fwdData = exMemAlu;
            FWD_EXMEM_LINK: fwdData = exMemLink;
            FWD_MEMWB:      fwdData = memWbData;
            default:        fwdData = rfData;
        endcase
    end

endmodule

// File: rtl/id_ex_rt_stage.sv
// ID/EX rt operand latch with forwarding mux and load-use stall control.
// Optional bubble counter enabled by defining ID_EX_RT_STALL_CNT_EN.
module id_ex_rt_stage
    import pipe_fwd_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   IF_ID_Instr,
    input  logic          IF_ID_isR_rs_rt_0,
    input  logic [2:0]    IF_ID_rt_FUnit_o,
    input  logic [DW-1:0] rf_rt_data,
    input  logic [DW-1:0] ID_EX_link,
    input  logic [DW-1:0] EX_MEM_alu,
    input  logic [DW-1:0] EX_MEM_link,
    input  logic [DW-1:0] MEM_WB_wdata,
    input  logic [31:0]   ID_EX_Instr,
    input  logic [31:0]   EX_MEM_Instr,
    input  logic          ID_EX_isLoad,
    input  logic          EX_MEM_isLoad,
    input  logic          flush,
    input  logic          hold,
    output logic [DW-1:0] ID_EX_rt_val,
    output logic          ID_EX_rt_vld,
    output logic          stall_o
`ifdef ID_EX_RT_STALL_CNT_EN
    ,
    output logic [CW-1:0] stall_cnt
`endif
);

    logic [1:0]    state;
    logic [4:0]    idRt;
    logic          hz;
    logic          loadStall;
    logic [DW-1:0] fwdData;

    // Only the rt fields of the surrounding instructions matter here.
    logic unusedBits;
    assign unusedBits = ^{IF_ID_Instr[31:21], IF_ID_Instr[15:0],
                          ID_EX_Instr[31:21], ID_EX_Instr[15:0],
                          EX_MEM_Instr[31:21], EX_MEM_Instr[15:0]};

    assign idRt = IF_ID_Instr[20:16];

    // A load still in EX or MEM targeting our rt cannot be forwarded in time.
    assign hz = IF_ID_isR_rs_rt_0 && (idRt != 5'd0) &&
                ((ID_EX_isLoad && (ID_EX_Instr[20:16] == idRt)) ||
                 (EX_MEM_isLoad && (EX_MEM_Instr[20:16] == idRt)));

    // Flush kills the dependent instruction, so it never needs a stall.
    assign loadStall = hz && !flush && ((state == ST_RUN) || (state == ST_STALL1));
    assign stall_o   = loadStall || hold;

    rt_fwd_mux #(.DW(DW)) uMux (
        .sel       (IF_ID_rt_FUnit_o),
        .rfData    (rf_rt_data),
        .idExLink  (ID_EX_link),
        .exMemAlu  (EX_MEM_alu),
        .exMemLink (EX_MEM_link),
        .memWbData (MEM_WB_wdata),
        .fwdData   (fwdData)
    );

    // Stall sequencer: at most two bubbles per load-use hazard, frozen by hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (hold) begin
            state <= state;
        end else if (flush) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:    state <= hz ? ST_STALL1 : ST_RUN;
                ST_STALL1: state <= hz ? ST_STALL2 : ST_RUN;
                ST_STALL2: state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // ID/EX rt latch: hold freezes, flush or stall inserts a bubble, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_rt_val <= '0;
            ID_EX_rt_vld <= 1'b0;
        end else if (hold) begin
            ID_EX_rt_val <= ID_EX_rt_val;
            ID_EX_rt_vld <= ID_EX_rt_vld;
        end else if (flush || loadStall) begin
            ID_EX_rt_val <= '0;
            ID_EX_rt_vld <= 1'b0;
        end else begin
            ID_EX_rt_val <= fwdData;
            ID_EX_rt_vld <= 1'b1;
        end
    end

`ifdef ID_EX_RT_STALL_CNT_EN
    // Saturating count of load-use bubbles actually inserted (hold cycles excluded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!hold && loadStall && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end
`else
    localparam int unusedCw = CW;
`endif

endmodule
